// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge.
//   - dsb_state_e : bridge FSM state encodings (IDLE=0, ADDR=1, DATA=2, DONE=3)
//   - Bus*        : bus widths, common to the instruction-side bridge
//   - word_addr() : byte address -> word-aligned bus address
package data_sram_bridge_pkg;

  localparam int unsigned BusAw = 32;
  localparam int unsigned BusDw = 32;
  localparam int unsigned BusSw = BusDw / 8;

  localparam logic [BusAw-1:0] WordMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } dsb_state_e;

  function automatic logic [BusAw-1:0] word_addr(input logic [BusAw-1:0] byte_addr);
    return byte_addr & WordMask;
  endfunction

endpackage

// File: rtl/dsb_timeout_cnt.sv
// Bus-wait timeout counter for the data SRAM bridge.
// Counts cycles while en_i is high, clears on clr_i, saturates at all-ones.
// Ports:
//   clk_i      core clock
//   rst_ni     synchronous active-low reset
//   clr_i      clear count to zero (bridge idle)
//   en_i       count this cycle (bridge waiting on the slave)
//   expired_o  high in the waiting cycle whose count equals Limit-1
// Limit = 0 disables expiry entirely.
module dsb_timeout_cnt #(
  parameter int unsigned Limit = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned Width = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [Width-1:0] LastCnt = (Limit == 0) ? '0 : Width'(Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (Limit != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side bridge between the MEM stage and a req/addr_ok/data_ok SRAM-like bus.
// A load/store seen in IDLE is issued as a bus request; the pipeline is stalled until the
// access completes, then released for one DONE cycle (the memenM still high in DONE belongs
// to the finished instruction and is not reissued). A timeout aborts hung accesses.
// Ports:
//   clk, rst (sync, active-low)        clock / reset
//   memenM, memwriteM, sig_write,
//   aluoutM, writedataM                M-stage access
//   readdataM                          load word to W stage
//   stall_memM                         freeze F/D/E/M
//   bus_errM                           one-cycle pulse on timeout abort
//   data_sram_req/wr/wstrb/addr/wdata  bus request side
//   data_sram_addr_ok/data_ok/rdata    bus response side
// Configuration macro DSRAM_RDATA_BYPASS_EN: when defined, data_ok in DATA releases the stall
// in the same cycle with rdata forwarded combinationally, and DONE is skipped (timeouts still
// pass through DONE).
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYC = 256,
  parameter logic [BusDw-1:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memenM,
  input  logic             memwriteM,
  input  logic [BusSw-1:0] sig_write,
  input  logic [BusAw-1:0] aluoutM,
  input  logic [BusDw-1:0] writedataM,
  output logic [BusDw-1:0] readdataM,
  output logic             stall_memM,
  output logic             bus_errM,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [BusSw-1:0] data_sram_wstrb,
  output logic [BusAw-1:0] data_sram_addr,
  output logic [BusDw-1:0] data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [BusDw-1:0] data_sram_rdata
);

  dsb_state_e       state_q;
  logic             wr_q;
  logic [BusSw-1:0] wstrb_q;
  logic [BusAw-1:0] addr_q;
  logic [BusDw-1:0] wdata_q;
  logic [BusDw-1:0] readdata_q;
  logic             bus_err_q;
  logic             expired;

  dsb_timeout_cnt #(
    .Limit (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (state_q == StIdle),
    .en_i      ((state_q == StAddr) || (state_q == StData)),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (memenM) begin
            // Capture the request so ADDR holds it stable regardless of the inputs.
            wr_q    <= memwriteM;
            wstrb_q <= memwriteM ? sig_write : '0;
            addr_q  <= word_addr(aluoutM);
            wdata_q <= writedataM;
            state_q <= data_sram_addr_ok ? StData : StAddr;
          end
        end
        StAddr: begin
          // Abort wins over a same-cycle addr_ok: the data phase could not finish in time.
          if (expired) begin
            state_q   <= StDone;
            bus_err_q <= 1'b1;
            if (!wr_q) readdata_q <= ERR_RDATA;
          end else if (data_sram_addr_ok) begin
            state_q <= StData;
          end
        end
        StData: begin
          // A response arriving in the expiring cycle is still a valid completion.
          if (data_sram_data_ok) begin
            if (!wr_q) readdata_q <= data_sram_rdata;
`ifdef DSRAM_RDATA_BYPASS_EN
            state_q <= StIdle;
`else
            state_q <= StDone;
`endif
          end else if (expired) begin
            state_q   <= StDone;
            bus_err_q <= 1'b1;
            if (!wr_q) readdata_q <= ERR_RDATA;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Bus side: driven only from state and memenM, never from addr_ok/data_ok.
  always_comb begin
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_wstrb = '0;
    data_sram_addr  = addr_q;
    data_sram_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        data_sram_req   = memenM;
        data_sram_wr    = memenM & memwriteM;
        data_sram_wstrb = (memenM && memwriteM) ? sig_write : '0;
        data_sram_addr  = word_addr(aluoutM);
        data_sram_wdata = writedataM;
      end
      StAddr: begin
        data_sram_req   = 1'b1;
        data_sram_wr    = wr_q;
        data_sram_wstrb = wstrb_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_memM = 1'b0;
    unique case (state_q)
      StIdle: stall_memM = memenM;
      StAddr: stall_memM = 1'b1;
`ifdef DSRAM_RDATA_BYPASS_EN
      StData: stall_memM = ~data_sram_data_ok;
`else
      StData: stall_memM = 1'b1;
`endif
      default: stall_memM = 1'b0;
    endcase
  end

`ifdef DSRAM_RDATA_BYPASS_EN
  assign readdataM = ((state_q == StData) && data_sram_data_ok && !wr_q) ? data_sram_rdata
                                                                         : readdata_q;
`else
  assign readdataM = readdata_q;
`endif

  assign bus_errM = bus_err_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed scenarios followed by randomized
// transactions with a scheduled slave, checked against a transaction-level model.
module tb_data_sram_bridge;

  localparam int unsigned TimeoutCyc = 8;
  localparam logic [31:0] ErrRdata   = 32'hDEAD_BEEF;
  localparam int          Never      = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM;
  logic [3:0]  sig_write;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stall_memM, bus_errM;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  data_sram_bridge #(
    .TIMEOUT_CYC (TimeoutCyc),
    .ERR_RDATA   (ErrRdata)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .memenM            (memenM),
    .memwriteM         (memwriteM),
    .sig_write         (sig_write),
    .aluoutM           (aluoutM),
    .writedataM        (writedataM),
    .readdataM         (readdataM),
    .stall_memM        (stall_memM),
    .bus_errM          (bus_errM),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One access. Slave schedule, counted in cycles from the first request cycle (k=0):
  // addr_ok at k==a, data_ok at k==a+d. Never means the slave stays silent.
  // Starts and ends on a negedge.
  task automatic run_txn(input bit st, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd, input int a, input int d,
                         input logic [31:0] rd, input bit spur);
    bit tout;
    bit done;
    int n_req, n_stall, exp_req, exp_stall;
    tout = (a == Never) || (d == Never);
    if (tout) begin
      exp_req   = (a == Never) ? TimeoutCyc + 1 : a + 1;
      exp_stall = TimeoutCyc + 1;
    end else begin
      exp_req = a + 1;
`ifdef DSRAM_RDATA_BYPASS_EN
      exp_stall = a + d;
`else
      exp_stall = a + d + 1;
`endif
    end
    done    = 1'b0;
    n_req   = 0;
    n_stall = 0;
    memenM     = 1'b1;
    memwriteM  = st;
    sig_write  = strb;
    aluoutM    = addr;
    writedataM = wd;
    for (int k = 0; k < 32 && !done; k++) begin
      data_sram_addr_ok = (k == a);
      // Optional stray data_ok before the address phase is accepted.
      data_sram_data_ok = (!tout && k == a + d) || (spur && k < a && k[0]);
      data_sram_rdata   = (!tout && k == a + d) ? rd : $urandom();
      #1;
      if (data_sram_req) begin
        n_req++;
        check("bus_addr", data_sram_addr, {addr[31:2], 2'b00});
        check("bus_wr", {31'd0, data_sram_wr}, {31'd0, st});
        check("bus_wstrb", {28'd0, data_sram_wstrb}, {28'd0, st ? strb : 4'h0});
        check("bus_wdata", data_sram_wdata, wd);
      end
      if (stall_memM) begin
        n_stall++;
        check("err_while_stalled", {31'd0, bus_errM}, 32'd0);
      end else begin
        done = 1'b1;
        if (!st) exp_rdata = tout ? ErrRdata : rd;
        check("req_cycles", n_req, exp_req);
        check("stall_cycles", n_stall, exp_stall);
        check("no_reissue", {31'd0, data_sram_req}, 32'd0);
        check("bus_err", {31'd0, bus_errM}, {31'd0, tout});
        check("readdata", readdataM, exp_rdata);
      end
      @(negedge clk);
    end
    check("txn_completes", {31'd0, done}, 32'd1);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  // Idle cycles with junk on the inputs; late pulses model responses from an aborted access.
  task automatic idle_cycles(input int n, input bit late);
    for (int i = 0; i < n; i++) begin
      memenM            = 1'b0;
      memwriteM         = 1'($urandom_range(0, 1));
      sig_write         = 4'($urandom_range(0, 15));
      aluoutM           = $urandom();
      writedataM        = $urandom();
      data_sram_addr_ok = late && (i == 0);
      data_sram_data_ok = late && (i == 1);
      data_sram_rdata   = $urandom();
      #1;
      check("idle_req", {31'd0, data_sram_req}, 32'd0);
      check("idle_stall", {31'd0, stall_memM}, 32'd0);
      check("idle_err", {31'd0, bus_errM}, 32'd0);
      check("idle_readdata", readdataM, exp_rdata);
      @(negedge clk);
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  // Reset while a load waits in the data phase; the late data_ok must be dropped.
  task automatic reset_in_data();
    memenM            = 1'b1;
    memwriteM         = 1'b0;
    sig_write         = 4'h0;
    aluoutM           = 32'h0000_0040;
    data_sram_addr_ok = 1'b1;
    data_sram_data_ok = 1'b0;
    #1;
    check("rst_txn_req", {31'd0, data_sram_req}, 32'd1);
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    #1;
    check("rst_txn_in_data", {31'd0, stall_memM}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    memenM = 1'b0;
    exp_rdata = 32'd0;
    #1;
    check("post_rst_req", {31'd0, data_sram_req}, 32'd0);
    check("post_rst_stall", {31'd0, stall_memM}, 32'd0);
    check("post_rst_readdata", readdataM, exp_rdata);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5A5A_1234;
    #1;
    check("late_ok_readdata", readdataM, exp_rdata);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    check("late_ok_readdata2", readdataM, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    bit st;
    int a, d, sel;
    rst               = 1'b0;
    memenM            = 1'b0;
    memwriteM         = 1'b0;
    sig_write         = 4'h0;
    aluoutM           = 32'd0;
    writedataM        = 32'd0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    exp_rdata         = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req", {31'd0, data_sram_req}, 32'd0);
    check("rst_wr", {31'd0, data_sram_wr}, 32'd0);
    check("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
    check("rst_stall", {31'd0, stall_memM}, 32'd0);
    check("rst_err", {31'd0, bus_errM}, 32'd0);
    check("rst_readdata", readdataM, exp_rdata);
    @(negedge clk);

    // Load, addr_ok with req, data_ok next cycle.
    run_txn(1'b0, 32'h0000_1000, 4'h0, 32'd0, 0, 1, 32'h1234_5678, 1'b0);
    idle_cycles(1, 1'b0);
    // Store, addr_ok delayed 3 cycles.
    run_txn(1'b1, 32'h8000_0006, 4'b1100, 32'hCAFE_0000, 3, 1, 32'h0BAD_0BAD, 1'b0);
    idle_cycles(1, 1'b0);
    // Back-to-back load then store, memenM high through DONE.
    run_txn(1'b0, 32'h0000_2004, 4'h0, 32'd0, 1, 2, 32'hA5A5_0001, 1'b1);
    run_txn(1'b1, 32'h0000_3001, 4'b0011, 32'h0000_BEEF, 0, 1, 32'h1111_2222, 1'b0);
    idle_cycles(1, 1'b0);
    // Hung slave on a load, then late responses.
    run_txn(1'b0, 32'h0000_4000, 4'h0, 32'd0, Never, 1, 32'd0, 1'b0);
    idle_cycles(3, 1'b1);
    // Address accepted but data never returns, on a store.
    run_txn(1'b1, 32'h0000_5008, 4'hF, 32'h7777_8888, 2, Never, 32'd0, 1'b0);
    idle_cycles(3, 1'b1);
    reset_in_data();

    for (int t = 0; t < 60; t++) begin
      st  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      a   = $urandom_range(0, 3);
      d   = $urandom_range(1, 4);
      if (sel == 0) a = Never;
      else if (sel == 1) d = Never;
      run_txn(st, $urandom(), 4'($urandom_range(1, 15)), $urandom(), a, d, $urandom(),
              1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2), (a == Never) || (d == Never));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
